// File: rtl/spine_pkg.sv
// Shared definitions for the spine crossbar router: header field layout,
// port classification and the group-to-port mapping.
package spine_pkg;

    typedef enum logic {
        PORT_LEAF  = 1'b0,
        PORT_GROUP = 1'b1
    } port_type_e;

    localparam int DEF_GRP_W  = 4;
    localparam int DEF_LEAF_W = 4;

    function automatic int grp_msb(input int dwidth);
        return dwidth - 1;
    endfunction

    function automatic int leaf_msb(input int dwidth, input int grp_w);
        return dwidth - 1 - grp_w;
    endfunction

    // Offset of the group link among the group ports; our own group has no link.
    function automatic int grp_to_port(input int dest_grp, input int group_id);
        return (dest_grp < group_id) ? dest_grp : dest_grp - 1;
    endfunction

endpackage

// File: rtl/spine_xbar_router_fifo.sv
// Per-input synchronous FIFO with first-word-fall-through head output.
module sync_fifo #(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [DWIDTH-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spine_xbar_router.sv
// Spine crossbar router: per-input FIFOs, header routing, per-output
// round-robin arbitration into registered outputs, unroutable-flit dropping.
module spine_xbar_router
    import spine_pkg::*;
#(
    parameter int GROUP_ID   = 2,
    parameter int NUM_LEAF   = 4,
    parameter int NUM_GROUP  = 7,
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int GRP_W      = DEF_GRP_W,
    parameter int LEAF_W     = DEF_LEAF_W
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [(NUM_LEAF+NUM_GROUP)*DWIDTH-1:0]     in_data,
    input  logic [NUM_LEAF+NUM_GROUP-1:0]              in_valid,
    output logic [NUM_LEAF+NUM_GROUP-1:0]              in_ready,
    output logic [(NUM_LEAF+NUM_GROUP)*DWIDTH-1:0]     out_data,
    output logic [NUM_LEAF+NUM_GROUP-1:0]              out_valid,
    input  logic [NUM_LEAF+NUM_GROUP-1:0]              out_ready,
    output logic [15:0]                                drop_count
);

    localparam int NP    = NUM_LEAF + NUM_GROUP;
    localparam int PW    = (NP > 1) ? $clog2(NP) : 1;
    localparam int G_MSB = grp_msb(DWIDTH);
    localparam int L_MSB = leaf_msb(DWIDTH, GRP_W);

    logic [DWIDTH-1:0] head [NP];
    logic [PW-1:0]     target [NP];
    logic [PW-1:0]     gnt_idx [NP];
    logic [NP-1:0]     req [NP];
    logic [NP-1:0]     fifo_full;
    logic [NP-1:0]     fifo_empty;
    logic [NP-1:0]     push;
    logic [NP-1:0]     pop;
    logic [NP-1:0]     routable;
    logic [NP-1:0]     drop;
    logic [NP-1:0]     grant;
    logic [15:0]       drop_next;
    int                drop_sum;

    assign in_ready = ~fifo_full & {NP{~reset}};
    assign push     = in_valid & in_ready;
    assign drop     = ~fifo_empty & ~routable;

    for (genvar p = 0; p < NP; p++) begin : g_in
        logic [GRP_W-1:0]  dgrp;
        logic [LEAF_W-1:0] dleaf;
        port_type_e        rtype;
        logic              route_ok;
        logic [PW-1:0]     route_port;

        sync_fifo #(
            .DWIDTH    (DWIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push   (push[p]),
            .pop    (pop[p]),
            .wr_data(in_data[p*DWIDTH +: DWIDTH]),
            .full   (fifo_full[p]),
            .empty  (fifo_empty[p]),
            .head   (head[p])
        );

        always_comb begin
            dgrp       = head[p][G_MSB -: GRP_W];
            dleaf      = head[p][L_MSB -: LEAF_W];
            rtype      = (int'(dgrp) == GROUP_ID) ? PORT_LEAF : PORT_GROUP;
            route_ok   = 1'b0;
            route_port = '0;
            if (rtype == PORT_LEAF) begin
                route_ok   = (int'(dleaf) < NUM_LEAF);
                route_port = PW'(dleaf);
            end else begin
                route_ok   = (int'(dgrp) <= NUM_GROUP);
                route_port = PW'(NUM_LEAF + grp_to_port(int'(dgrp), GROUP_ID));
            end
        end

        assign routable[p] = route_ok;
        assign target[p]   = route_port;
    end

    for (genvar o = 0; o < NP; o++) begin : g_out
        logic              arb_found;
        logic [PW-1:0]     arb_pick;
        logic [PW-1:0]     last_grant;
        logic              vld_q;
        logic [DWIDTH-1:0] data_q;
        int                idx;

        for (genvar p = 0; p < NP; p++) begin : g_req
            assign req[o][p] = ~fifo_empty[p] & routable[p] & (target[p] == PW'(o));
        end

        // Scan from the input after the last winner so every requester is reached within NP grants.
        always_comb begin
            arb_found = 1'b0;
            arb_pick  = last_grant;
            idx       = 0;
            for (int k = 1; k <= NP; k++) begin
                idx = int'(last_grant) + k;
                if (idx >= NP) begin
                    idx = idx - NP;
                end
                if (!arb_found && req[o][idx]) begin
                    arb_found = 1'b1;
                    arb_pick  = PW'(idx);
                end
            end
        end

        assign grant[o]   = arb_found & (~vld_q | out_ready[o]);
        assign gnt_idx[o] = arb_pick;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q      <= 1'b0;
                data_q     <= '0;
                last_grant <= PW'(NP - 1);
            end else if (grant[o]) begin
                vld_q      <= 1'b1;
                data_q     <= head[arb_pick];
                last_grant <= arb_pick;
            end else if (out_ready[o]) begin
                vld_q      <= 1'b0;
            end
        end

        assign out_valid[o]                  = vld_q;
        assign out_data[o*DWIDTH +: DWIDTH]  = data_q;
    end

    always_comb begin
        pop = drop;
        for (int o = 0; o < NP; o++) begin
            for (int p = 0; p < NP; p++) begin
                if (grant[o] && (int'(gnt_idx[o]) == p)) begin
                    pop[p] = 1'b1;
                end
            end
        end
    end

    // Several inputs may drop in one cycle; each dropped flit counts once.
    always_comb begin
        drop_sum = int'(drop_count);
        for (int p = 0; p < NP; p++) begin
            if (drop[p]) begin
                drop_sum = drop_sum + 1;
            end
        end
        drop_next = (drop_sum > 65535) ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_next;
        end
    end

endmodule

// File: tb/tb_spine_xbar_router.sv
// Self-checking bench for spine_xbar_router: directed scenarios plus a
// randomized run scored against a per-(source,destination) queue model.
module tb_spine_xbar_router;

    localparam int NP    = 11;
    localparam int DW    = 16;
    localparam int GID   = 2;
    localparam int NL    = 4;
    localparam int NG    = 7;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP*DW-1:0] in_data;
    logic [NP*DW-1:0] out_data;
    logic [NP-1:0]   in_valid;
    logic [NP-1:0]   in_ready;
    logic [NP-1:0]   out_valid;
    logic [NP-1:0]   out_ready;
    logic [15:0]     drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] sbq [NP*NP][$];
    int          model_drops;
    logic [3:0]  seq [NP];
    logic [NP-1:0] held;
    logic [15:0] held_data [NP];

    spine_xbar_router #(
        .GROUP_ID  (GID),
        .NUM_LEAF  (NL),
        .NUM_GROUP (NG),
        .DWIDTH    (DW),
        .FIFO_DEPTH(DEPTH),
        .GRP_W     (4),
        .LEAF_W    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkFlit(input int g, input int l, input int s, input logic [3:0] q);
        return {4'(g), 4'(l), 4'(s), q};
    endfunction

    function automatic logic [15:0] outFlit(input int o);
        return out_data[o*DW +: DW];
    endfunction

    // Destination port from the header rules; -1 means the flit must be dropped.
    function automatic int modelRoute(input logic [15:0] f);
        int g;
        int l;
        g = int'(f[15:12]);
        l = int'(f[11:8]);
        if (g == GID) return (l < NL) ? l : -1;
        if (g > NG) return -1;
        return NL + ((g < GID) ? g : g - 1);
    endfunction

    task automatic applyStimulus(input int port, input logic [15:0] flit);
        in_data[port*DW +: DW] = flit;
        in_valid[port] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[port] = 1'b0;
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic processOutputs();
        for (int o = 0; o < NP; o++) begin
            logic [15:0] d;
            int s;
            d = outFlit(o);
            if (held[o]) begin
                checkOutput("hold_valid", 32'(out_valid[o]), 32'd1);
                checkOutput("hold_data", 32'(d), 32'(held_data[o]));
            end
            held[o]      = out_valid[o] & ~out_ready[o];
            held_data[o] = d;
            if (out_valid[o] && out_ready[o]) begin
                s = int'(d[7:4]);
                checkOutput("rand_src_port", 32'(s < NP), 32'd1);
                if (s < NP) begin
                    checkOutput("rand_expected_flit", 32'(sbq[s*NP+o].size() > 0), 32'd1);
                    if (sbq[s*NP+o].size() > 0) begin
                        checkOutput("rand_data", 32'(d), 32'(sbq[s*NP+o].pop_front()));
                    end
                end
            end
        end
    endtask

    task automatic processInputs();
        for (int p = 0; p < NP; p++) begin
            if (in_valid[p] && in_ready[p]) begin
                logic [15:0] f;
                int r;
                f = in_data[p*DW +: DW];
                r = modelRoute(f);
                if (r < 0) model_drops++;
                else sbq[p*NP+r].push_back(f);
                seq[p] = seq[p] + 4'd1;
            end
        end
    endtask

    initial begin
        int grps [4];
        int ports [4];
        int acc;
        int rcv;
        int total;
        logic [NP-1:0] anyv;

        grps  = '{0, 1, 3, 7};
        ports = '{4, 5, 6, 10};

        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data_p0", 32'(outFlit(0)), 32'd0);
        checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'h7FF);

        // Local delivery with minimum latency.
        applyStimulus(0, 16'h21AB);
        @(negedge clk);
        checkOutput("local_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("local_cycle2_valid", 32'(out_valid), 32'h2);
        checkOutput("local_cycle2_data", 32'(outFlit(1)), 32'h21AB);

        // Inter-group port mapping.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, mkFlit(grps[i], 0, 0, 4'(i)));
            @(negedge clk);
            @(negedge clk);
            checkOutput($sformatf("group%0d_valid", grps[i]), 32'(out_valid), 32'(1 << ports[i]));
            checkOutput($sformatf("group%0d_data", grps[i]), 32'(outFlit(ports[i])),
                        32'(mkFlit(grps[i], 0, 0, 4'(i))));
        end

        // Round-robin contention on leaf 3.
        resetDut();
        for (int p = 0; p < 3; p++) begin
            in_data[p*DW +: DW] = mkFlit(GID, 3, p, 4'd0);
            in_valid[p] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_valid_%0d", k), 32'(out_valid[3]), 32'd1);
            checkOutput($sformatf("rr_src_%0d", k), 32'(outFlit(3) >> 4) & 32'hF, 32'(k % 3));
        end
        #1;
        in_valid = '0;

        // Backpressure: output register plus full FIFO, then in-order drain.
        resetDut();
        out_ready[3] = 1'b0;
        in_valid[0]  = 1'b1;
        acc = 0;
        for (int it = 0; it < 15; it++) begin
            in_data[0 +: DW] = mkFlit(GID, 3, 0, 4'(acc));
            @(negedge clk);
            if (in_ready[0]) acc++;
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        checkOutput("bp_accepted", 32'(acc), 32'd9);
        @(negedge clk);
        checkOutput("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
        checkOutput("bp_reg_valid", 32'(out_valid[3]), 32'd1);
        checkOutput("bp_reg_data", 32'(outFlit(3)), 32'(mkFlit(GID, 3, 0, 4'd0)));
        out_ready[3] = 1'b1;
        rcv = 0;
        for (int it = 0; it < 30; it++) begin
            if (out_valid[3]) begin
                checkOutput($sformatf("bp_drain_%0d", rcv), 32'(outFlit(3)), 32'(mkFlit(GID, 3, 0, 4'(rcv))));
                rcv++;
            end
            @(negedge clk);
        end
        checkOutput("bp_drain_count", 32'(rcv), 32'd9);

        // Drops and saturation.
        resetDut();
        applyStimulus(0, mkFlit(9, 0, 0, 4'd0));
        applyStimulus(0, mkFlit(GID, 5, 0, 4'd1));
        anyv = '0;
        repeat (5) begin
            @(negedge clk);
            anyv = anyv | out_valid;
        end
        checkOutput("drop_no_output", 32'(anyv), 32'd0);
        checkOutput("drop_count_two", 32'(drop_count), 32'd2);
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = mkFlit(15, 0, p, 4'd0);
        in_valid = '1;
        repeat (6000) @(posedge clk);
        #1;
        in_valid = '0;
        @(negedge clk);
        checkOutput("drop_saturated", 32'(drop_count), 32'hFFFF);
        applyStimulus(0, mkFlit(12, 0, 0, 4'd0));
        repeat (3) @(negedge clk);
        checkOutput("drop_stays_saturated", 32'(drop_count), 32'hFFFF);

        // Reset with buffered flits.
        resetDut();
        out_ready = '0;
        in_data[0 +: DW]  = mkFlit(GID, 2, 0, 4'd0);
        in_data[DW +: DW] = mkFlit(GID, 3, 1, 4'd0);
        in_valid[1:0] = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        in_valid = '0;
        resetDut();
        anyv = '0;
        repeat (6) begin
            @(negedge clk);
            anyv = anyv | out_valid;
        end
        checkOutput("midreset_no_stale", 32'(anyv), 32'd0);
        checkOutput("midreset_drop_count", 32'(drop_count), 32'd0);
        applyStimulus(5, mkFlit(GID, 0, 5, 4'd3));
        @(negedge clk);
        checkOutput("midreset_first_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("midreset_first_valid", 32'(out_valid), 32'h1);
        checkOutput("midreset_first_data", 32'(outFlit(0)), 32'(mkFlit(GID, 0, 5, 4'd3)));

        // Randomized traffic against the queue model.
        @(posedge clk);
        #1;
        resetDut();
        model_drops = 0;
        held = '0;
        for (int p = 0; p < NP; p++) seq[p] = 4'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                int r;
                int g;
                int l;
                r = $urandom_range(0, 9);
                if (r < 4) begin
                    g = GID;
                    l = $urandom_range(0, 5);
                end else if (r < 9) begin
                    g = $urandom_range(0, NG - 1);
                    if (g >= GID) g++;
                    l = $urandom_range(0, 15);
                end else begin
                    g = $urandom_range(NG + 1, 15);
                    l = $urandom_range(0, 15);
                end
                in_data[p*DW +: DW] = mkFlit(g, l, p, seq[p]);
                in_valid[p]  = ($urandom_range(0, 99) < 35);
                out_ready[p] = ($urandom_range(0, 99) < 70);
            end
            @(negedge clk);
            processOutputs();
            processInputs();
            @(posedge clk);
            #1;
        end
        in_valid  = '0;
        out_ready = '1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            processOutputs();
            @(posedge clk);
            #1;
        end
        total = 0;
        for (int k = 0; k < NP*NP; k++) total += sbq[k].size();
        checkOutput("rand_leftover", 32'(total), 32'd0);
        checkOutput("rand_drop_count", 32'(drop_count), 32'(model_drops));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
